// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: shared writeback types and constants (result request record, idle address, pointer helper)
package writeback_arbiter_pkg;
  localparam int WB_AWIDTH = 7;
  localparam int WB_DWIDTH = 32;
  localparam int WB_IDLE_ADDR = 0;
  typedef struct packed {
    logic [WB_AWIDTH-1:0] addr;
    logic [WB_DWIDTH-1:0] data;
  } WB_REQUEST;
  function automatic int wb_next_ptr(input int g, input int n);
    return (g + 1) % n;
  endfunction
endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/ptr in, one-hot grant, encoded idx and any-grant out
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int W = $clog2(N);
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any = 1'b1;
        grant[j] = 1'b1;
        idx = W'(j);
      end
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: per-unit one-entry result buffers drained round-robin into the register bank write port
// Ports: clk, reset (async, active-high), req_valid_i/req_addr_i/req_data_i/req_ready_o per unit,
// write_address/write_data (registered, address 0 = no write), and with WB_ARB_WAKEUP_EN defined
// wakeup_valid_o/wakeup_addr_o, an early copy of the current grant one cycle ahead of the write.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DWIDTH = WB_DWIDTH,
  parameter int AWIDTH = WB_AWIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ-1:0][AWIDTH-1:0]  req_addr_i,
  input  logic [N_REQ-1:0][DWIDTH-1:0]  req_data_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic [AWIDTH-1:0]             write_address,
  output logic [DWIDTH-1:0]             write_data
`ifdef WB_ARB_WAKEUP_EN
  ,
  output logic                          wakeup_valid_o,
  output logic [AWIDTH-1:0]             wakeup_addr_o
`endif
);
  localparam int PW = $clog2(N_REQ);
  localparam logic [AWIDTH-1:0] IDLE = AWIDTH'(WB_IDLE_ADDR);
  logic [N_REQ-1:0] full_q, grant, accept, keep;
  logic [AWIDTH-1:0] addr_q [N_REQ];
  logic [DWIDTH-1:0] data_q [N_REQ];
  logic [PW-1:0] ptr_q, gidx;
  logic any;
  rr_arbiter #(.N(N_REQ)) u_rr (
    .req  (full_q),
    .ptr  (ptr_q),
    .grant(grant),
    .idx  (gidx),
    .any  (any)
  );
  // A buffer being drained this cycle can take a new result in the same edge.
  assign req_ready_o = ~full_q | grant;
  // Results for address 0 are handshaken but never buffered.
  always_comb begin
    accept = req_valid_i & req_ready_o;
    keep = '0;
    for (int i = 0; i < N_REQ; i++) keep[i] = accept[i] & (req_addr_i[i] != IDLE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      ptr_q <= '0;
      write_address <= IDLE;
      write_data <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        full_q[i] <= keep[i] | (full_q[i] & ~grant[i]);
        if (keep[i]) begin
          addr_q[i] <= req_addr_i[i];
          data_q[i] <= req_data_i[i];
        end
      end
      write_address <= any ? addr_q[gidx] : IDLE;
      write_data <= any ? data_q[gidx] : '0;
      if (any) ptr_q <= PW'(wb_next_ptr(int'(gidx), N_REQ));
    end
  end
`ifdef WB_ARB_WAKEUP_EN
  assign wakeup_valid_o = any;
  assign wakeup_addr_o = any ? addr_q[gidx] : IDLE;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed self-checking bench for writeback_arbiter with N_REQ=2
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req_valid_i;
  logic [1:0][6:0] req_addr_i;
  logic [1:0][31:0] req_data_i;
  logic [1:0] req_ready_o;
  logic [6:0] write_address;
  logic [31:0] write_data;
`ifdef WB_ARB_WAKEUP_EN
  logic wakeup_valid_o;
  logic [6:0] wakeup_addr_o;
`endif
  int total = 0;
  int fails = 0;
  writeback_arbiter #(.N_REQ(2), .DWIDTH(32), .AWIDTH(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .write_address(write_address),
    .write_data   (write_data)
`ifdef WB_ARB_WAKEUP_EN
    ,
    .wakeup_valid_o(wakeup_valid_o),
    .wakeup_addr_o (wakeup_addr_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int c0, c1, w0, w1, maxw, n;
    logic a0, a1;
    logic [6:0] ea;
    reset = 1'b1;
    req_valid_i = '0;
    req_addr_i = '0;
    req_data_i = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_addr", write_address, 0);
    chk("rst_data", write_data, 0);
    chk("rst_ready", req_ready_o, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_addr", write_address, 0);
      chk("idle_data", write_data, 0);
      chk("idle_ready", req_ready_o, 2'b11);
    end
    req_valid_i = 2'b01;
    req_addr_i[0] = 7'd5;
    req_data_i[0] = 32'h1234;
    chk("single_ready_pre", req_ready_o[0], 1'b1);
    step();
    req_valid_i = '0;
    chk("single_addr_e0", write_address, 0);
    chk("single_ready_held", req_ready_o[0], 1'b1);
`ifdef WB_ARB_WAKEUP_EN
    chk("single_wake_v", wakeup_valid_o, 1'b1);
    chk("single_wake_a", wakeup_addr_o, 7'd5);
`endif
    step();
    chk("single_addr", write_address, 7'd5);
    chk("single_data", write_data, 32'h1234);
    step();
    chk("single_after", write_address, 0);
    req_valid_i = 2'b10;
    req_addr_i[1] = 7'd0;
    req_data_i[1] = 32'hFFFF;
    chk("zero_ready", req_ready_o[1], 1'b1);
    step();
    req_valid_i = '0;
    chk("zero_not_full", req_ready_o, 2'b11);
    chk("zero_addr0", write_address, 0);
    step();
    chk("zero_addr1", write_address, 0);
    chk("zero_data1", write_data, 0);
    req_valid_i = 2'b11;
    req_addr_i[0] = 7'd20;
    req_data_i[0] = 32'hAAAA;
    req_addr_i[1] = 7'd50;
    req_data_i[1] = 32'hBBBB;
    step();
    req_valid_i = '0;
    reset = 1'b1;
    #1;
    chk("rstmid_ready", req_ready_o, 2'b11);
    chk("rstmid_addr", write_address, 0);
    step();
    chk("rstmid_addr_edge", write_address, 0);
    reset = 1'b0;
    step();
    chk("post_rst_nowrite", write_address, 0);
    chk("post_rst_nodata", write_data, 0);
    c0 = 0;
    c1 = 0;
    w0 = 0;
    w1 = 0;
    maxw = 0;
    for (int s = 0; s < 10; s++) begin
      req_valid_i = 2'b11;
      req_addr_i[0] = 7'(10 + c0);
      req_data_i[0] = 32'h1000 + 32'(10 + c0);
      req_addr_i[1] = 7'(40 + c1);
      req_data_i[1] = 32'h1000 + 32'(40 + c1);
      a0 = req_ready_o[0];
      a1 = req_ready_o[1];
      w0 = a0 ? 0 : w0 + 1;
      w1 = a1 ? 0 : w1 + 1;
      if (w0 > maxw) maxw = w0;
      if (w1 > maxw) maxw = w1;
      step();
      if (a0) c0++;
      if (a1) c1++;
      if (s == 0) chk("alt_first_idle", write_address, 0);
      else begin
        n = s - 1;
        ea = (n % 2 == 0) ? 7'(10 + n / 2) : 7'(40 + n / 2);
        chk("alt_addr", write_address, ea);
        chk("alt_data", write_data, 32'h1000 + 32'(ea));
      end
    end
    chk("alt_max_wait", maxw <= 1, 1'b1);
    req_valid_i = '0;
    for (int i = 0; i < 4; i++) step();
    chk("drained_ready", req_ready_o, 2'b11);
    chk("drained_addr", write_address, 0);
    req_valid_i = 2'b01;
    req_addr_i[0] = 7'd7;
    req_data_i[0] = 32'h77;
    step();
    req_valid_i = '0;
`ifdef WB_ARB_WAKEUP_EN
    chk("wake_valid", wakeup_valid_o, 1'b1);
    chk("wake_addr", wakeup_addr_o, 7'd7);
`endif
    chk("wake_pre_addr", write_address, 0);
    step();
    chk("wake_write_addr", write_address, 7'd7);
    chk("wake_write_data", write_data, 32'h77);
`ifdef WB_ARB_WAKEUP_EN
    chk("wake_valid_off", wakeup_valid_o, 1'b0);
    chk("wake_addr_off", wakeup_addr_o, 0);
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Shares the register bank's single write port between N_REQ execution units (ALU pipes, load unit, future multiplier). Each requester deposits a result into a private one-entry holding buffer. A round-robin arbiter drains one buffer per cycle into the registered write_address/write_data pair that drives the register bank. The bank uses that same pair to set register_valid bits, which wake the scheduler.

## Interface
- N_REQ, 2, number of requesting units (2..8)
- DWIDTH, 32, result data width
- AWIDTH, 7, physical register address width (128 physical registers)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid_i  in  N_REQ  per-requester result valid
- req_addr_i  in  N_REQ x AWIDTH  destination physical register
- req_data_i  in  N_REQ x DWIDTH  result value
- req_ready_o  out  N_REQ  holding buffer can accept this cycle
- write_address  out  AWIDTH  register bank write address; 0 = no write
- write_data  out  DWIDTH  register bank write data
- wakeup_valid_o  out  1  early wakeup strobe (only with WB_ARB_WAKEUP_EN)
- wakeup_addr_o  out  AWIDTH  early wakeup register (only with WB_ARB_WAKEUP_EN)

## Operation
- Per requester i: buffer full_q[i], addr_q[i], data_q[i].
- Accept on valid & ready. req_addr_i == 0 is accepted and discarded: ready is returned and full_q is not set.
- Arbitration is combinational over full_q[], round-robin. The search starts at pointer ptr_q and the lowest index at or after ptr_q wins.
- On a grant g:
  - write_address <= addr_q[g], write_data <= data_q[g], full_q[g] cleared.
  - ptr_q <= (g+1) mod N_REQ.
- With no grant: write_address <= 0, write_data <= 0, ptr_q unchanged.
- req_ready_o[i] = !full_q[i] | grant[i]. A buffer drained this cycle refills in the same cycle, which sustains one result per cycle per requester when it is uncontended.
- Simultaneous grant and accept on the same i: the new value is loaded and full_q[i] stays 1.
- Two buffers holding the same addr are not checked. Renaming guarantees this does not happen.
- Reset values: full_q = 0, ptr_q = 0, write_address = 0, write_data = 0, req_ready_o = all 1 (combinational from full_q), wakeup_valid_o = 0, wakeup_addr_o = 0.
- Reset mid-operation discards all buffered results. No write is issued after reset deasserts until a new accept.

## Timing
- Latency from accept edge E to write_address valid: 1 cycle (visible after E+1) when uncontended.
- Worst-case wait under full contention: N_REQ cycles after acceptance.
- Throughput: 1 write per cycle aggregate.
- Starvation-free: a full buffer is granted within N_REQ cycles.
- req_ready_o is combinational from registered state and the current grant. It has no path from req_valid_i.

## Configuration
- Macro: WB_ARB_WAKEUP_EN.
- Defined:
  - wakeup_valid_o / wakeup_addr_o present and driven combinationally from the current grant (valid = any grant, addr = addr_q[g]).
  - The scheduler can wake dependents one cycle before write_address updates register_valid.
  - Outputs are 0 when no grant and during reset.
- Undefined: both ports are absent. Wakeup comes only through register_valid one cycle after the write.

## Structure
- Shared ISA package: typedef WB_REQUEST (addr AWIDTH, data DWIDTH) and localparam WB_IDLE_ADDR = 0.
- Sub-module rr_arbiter(N):
  - Purely combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Instantiated once.
- The top level holds the buffers, pointer and output registers.

## Test plan
- Reset, then no requests -> write_address = 0 and write_data = 0 every cycle, req_ready_o = 2'b11.
- N_REQ=2, only req0 presents (addr 5, data 0x1234) -> write_address = 5 and write_data = 0x1234 exactly one cycle after accept, req_ready_o[0] stays 1.
- Both requesters valid every cycle with addresses 10,11,12… and 40,41,42… -> writes alternate 10,40,11,41,… and neither requester waits more than 2 cycles.
- req1 presents addr 0 with data 0xFFFF -> accepted (ready = 1), no write issued, write_address stays 0.
- Assert reset while both buffers are full -> next cycle write_address = 0, full_q cleared, ptr_q = 0, and the first post-reset contended grant goes to req0.
- With WB_ARB_WAKEUP_EN defined, req0 addr 7 -> wakeup_valid_o = 1 and wakeup_addr_o = 7 in the cycle before write_address = 7.
